// File: rtl/block_reduce_pkg.sv
// Shared types and sizing helpers for the block_reduce slice.
// Optional argmax output is enabled by defining BLOCK_REDUCE_ARGMAX_EN.
package block_reduce_pkg;

  typedef enum logic [1:0] {IDLE, REQ, COLLECT, DONE} reduce_state_t;

  localparam int N_DEF     = 32;
  localparam int DEPTH_DEF = 64;

  function automatic int cnt_w(input int depth);
    return $clog2(depth);
  endfunction

  // Sum of depth words of n bits needs n + log2(depth) bits to never wrap.
  function automatic int acc_w(input int n, input int depth);
    return n + $clog2(depth);
  endfunction

  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);
  localparam int ACC_W_DEF = acc_w(N_DEF, DEPTH_DEF);

endpackage

// File: rtl/reduce_datapath.sv
// Sum / max (and optional argmax, BLOCK_REDUCE_ARGMAX_EN) registers for block_reduce.
module reduce_datapath #(
  parameter int N     = 32,
  parameter int CNT_W = 6,
  parameter int ACC_W = N + CNT_W
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N-1:0]     data,
`ifdef BLOCK_REDUCE_ARGMAX_EN
  input  logic [CNT_W-1:0] idx,
`endif
  output logic [ACC_W-1:0] sum,
  output logic [N-1:0]     max_val
`ifdef BLOCK_REDUCE_ARGMAX_EN
  ,
  output logic [CNT_W-1:0] max_idx
`endif
);

  // NOTE: registers use non-blocking assignments and a synchronous reset that
  // is sampled only on the clock edge, so every flop here updates together.
  always_ff @(posedge CLK) begin
    if (rst || clr) begin
      sum     <= '0;
      max_val <= '0;
`ifdef BLOCK_REDUCE_ARGMAX_EN
      max_idx <= '0;
`endif
    end else if (en) begin
      sum <= sum + ACC_W'(data);
      // Strict compare keeps the earliest occurrence on ties.
      if (data > max_val) begin
        max_val <= data;
`ifdef BLOCK_REDUCE_ARGMAX_EN
        max_idx <= idx;
`endif
      end
    end
  end

endmodule

// File: rtl/block_reduce.sv
// Requests one block from the multiplier, reduces it to sum and max, and hands
// the result downstream on valid/ready. BLOCK_REDUCE_ARGMAX_EN adds max_idx.
module block_reduce
  import block_reduce_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = cnt_w(DEPTH),
  parameter int ACC_W = N + CNT_W
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  output logic             EN_blockRead,
  input  logic             VALID_memVal,
  input  logic [N-1:0]     memVal_data,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [N-1:0]     max_out,
  output logic             overrun
`ifdef BLOCK_REDUCE_ARGMAX_EN
  ,
  output logic [CNT_W-1:0] max_idx
`endif
);

  reduce_state_t    state;
  logic [CNT_W-1:0] count;
  logic             beat_en;
  logic             acc_clr;
  logic             last_beat;

  // A beat is accepted in REQ as well, where it becomes beat 0.
  assign beat_en   = VALID_memVal && (state == REQ || state == COLLECT);
  assign acc_clr   = start && (state == IDLE || (state == DONE && res_ready));
  assign last_beat = (count == CNT_W'(DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      EN_blockRead <= 1'b0;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (VALID_memVal) overrun <= 1'b1;
          if (start) begin
            state        <= REQ;
            count        <= '0;
            EN_blockRead <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ, COLLECT: begin
          if (VALID_memVal) begin
            EN_blockRead <= 1'b0;
            if (last_beat) begin
              state     <= DONE;
              count     <= '0;
              res_valid <= 1'b1;
            end else begin
              state <= COLLECT;
              count <= count + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (VALID_memVal) overrun <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            if (start) begin
              state        <= REQ;
              EN_blockRead <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  reduce_datapath #(
    .N     (N),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .CLK     (CLK),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (beat_en),
    .data    (memVal_data),
`ifdef BLOCK_REDUCE_ARGMAX_EN
    .idx     (count),
`endif
    .sum     (sum_out),
    .max_val (max_out)
`ifdef BLOCK_REDUCE_ARGMAX_EN
    ,
    .max_idx (max_idx)
`endif
  );

endmodule

// File: tb/tb_block_reduce.sv
// Scoreboard bench for block_reduce: a block-level model predicts each result,
// a negedge monitor pops and compares on every res_valid/res_ready handshake.
module tb_block_reduce;

  localparam int N     = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = 6;
  localparam int ACC_W = 38;

  logic             CLK;
  logic             rst;
  logic             start;
  logic             EN_blockRead;
  logic             VALID_memVal;
  logic [N-1:0]     memVal_data;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] sum_out;
  logic [N-1:0]     max_out;
  logic             overrun;
`ifdef BLOCK_REDUCE_ARGMAX_EN
  logic [CNT_W-1:0] max_idx;
`endif

  block_reduce dut (
    .CLK          (CLK),
    .rst          (rst),
    .start        (start),
    .EN_blockRead (EN_blockRead),
    .VALID_memVal (VALID_memVal),
    .memVal_data  (memVal_data),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .sum_out      (sum_out),
    .max_out      (max_out),
    .overrun      (overrun)
`ifdef BLOCK_REDUCE_ARGMAX_EN
    ,
    .max_idx      (max_idx)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] sum;
    logic [31:0] mx;
    int          idx;
  } res_t;

  res_t        exp_q[$];
  logic [31:0] blk [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          results = 0;
  int          en_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of all words, largest word, first index holding it.
  function automatic res_t model();
    res_t r;
    r.sum = '0;
    r.mx  = '0;
    r.idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      r.sum += 64'(blk[i]);
      if (blk[i] > r.mx) r.mx = blk[i];
    end
    for (int i = DEPTH - 1; i >= 0; i--)
      if (blk[i] == r.mx) r.idx = i;
    return r;
  endfunction

  always @(negedge CLK) begin
    if (EN_blockRead) en_cycles++;
    if (!rst && res_valid && res_ready) begin
      res_t e;
      results++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h with no result expected", sum_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_sum", 64'(sum_out), e.sum);
        check("sb_max", 64'(max_out), 64'(e.mx));
`ifdef BLOCK_REDUCE_ARGMAX_EN
        check("sb_idx", 64'(max_idx), 64'(e.idx));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("en_after_start", 64'(EN_blockRead), 64'd1);
  endtask

  // Drive nbeats beats of blk with up to gap_max idle cycles before each;
  // start is pulsed alongside beat start_at (negative for never).
  task automatic drive_beats(input int gap_max, input int nbeats, input int start_at);
    for (int i = 0; i < nbeats; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      VALID_memVal = 1'b1;
      memVal_data  = blk[i];
      start        = (i == start_at);
      if (i == DEPTH - 1) check("valid_before_last", 64'(res_valid), 64'd0);
      tick();
      VALID_memVal = 1'b0;
      start        = 1'b0;
    end
    if (nbeats == DEPTH) check("latency", 64'(res_valid), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   en_base;
    int   res_base;
    res_t held;

    rst          = 1'b1;
    start        = 1'b0;
    VALID_memVal = 1'b0;
    memVal_data  = '0;
    res_ready    = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(EN_blockRead), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_sum", 64'(sum_out), 64'd0);
    rst = 1'b0;
    tick();

    // Beats 1..64 back to back.
    for (int i = 0; i < DEPTH; i++) blk[i] = 32'(i + 1);
    exp_q.push_back(model());
    en_base = en_cycles;
    issue_start();
    drive_beats(0, DEPTH, -1);
    check("t1_sum", 64'(sum_out), 64'd2080);
    check("t1_max", 64'(max_out), 64'd64);
    check("t1_en_cycles", 64'(en_cycles - en_base), 64'd1);
    wait_drain("t1_drain");

    // All ones words with random gaps.
    for (int i = 0; i < DEPTH; i++) blk[i] = 32'hFFFF_FFFF;
    exp_q.push_back(model());
    issue_start();
    drive_beats(3, DEPTH, -1);
    check("t2_sum", 64'(sum_out), 64'h3F_FFFF_FFC0);
    check("t2_max", 64'(max_out), 64'hFFFF_FFFF);
    check("t2_overrun", 64'(overrun), 64'd0);
    wait_drain("t2_drain");

    // Tie for the maximum: first occurrence wins.
    for (int i = 0; i < DEPTH; i++) blk[i] = 32'd5;
    blk[10] = 32'd9;
    blk[40] = 32'd9;
    exp_q.push_back(model());
    issue_start();
    drive_beats(1, DEPTH, -1);
    check("t3_sum", 64'(sum_out), 64'd328);
    check("t3_max", 64'(max_out), 64'd9);
`ifdef BLOCK_REDUCE_ARGMAX_EN
    check("t3_idx", 64'(max_idx), 64'd10);
`endif
    wait_drain("t3_drain");

    // Random small-valued blocks so ties are common.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < DEPTH; i++) blk[i] = $urandom_range(0, 7);
      exp_q.push_back(model());
      issue_start();
      drive_beats(2, DEPTH, -1);
      wait_drain("rand_drain");
    end

    // Backpressure in DONE with a stray beat, then handshake plus restart.
    for (int i = 0; i < DEPTH; i++) blk[i] = $urandom;
    exp_q.push_back(model());
    held = exp_q[0];
    res_ready = 1'b0;
    issue_start();
    drive_beats(1, DEPTH, -1);
    for (int c = 0; c < 20; c++) begin
      VALID_memVal = (c == 5);
      memVal_data  = $urandom;
      tick();
      VALID_memVal = 1'b0;
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_sum", 64'(sum_out), held.sum);
      check("hold_max", 64'(max_out), 64'(held.mx));
    end
    check("stray_overrun", 64'(overrun), 64'd1);
    res_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("restart_en", 64'(EN_blockRead), 64'd1);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_valid", 64'(res_valid), 64'd0);
    check("restart_popped", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < DEPTH; i++) blk[i] = $urandom;
    exp_q.push_back(model());
    drive_beats(2, DEPTH, -1);
    wait_drain("restart_drain");

    // Reset mid-block discards the partial block.
    for (int i = 0; i < DEPTH; i++) blk[i] = $urandom;
    issue_start();
    drive_beats(1, 30, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_en", 64'(EN_blockRead), 64'd0);
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_overrun", 64'(overrun), 64'd0);
    check("mid_rst_sum", 64'(sum_out), 64'd0);
    check("mid_rst_max", 64'(max_out), 64'd0);
    tick();
    for (int i = 0; i < DEPTH; i++) blk[i] = 32'd1;
    exp_q.push_back(model());
    issue_start();
    drive_beats(0, DEPTH, -1);
    check("after_rst_sum", 64'(sum_out), 64'd64);
    wait_drain("after_rst_drain");

    // start while collecting is ignored.
    for (int i = 0; i < DEPTH; i++) blk[i] = $urandom;
    exp_q.push_back(model());
    en_base  = en_cycles;
    res_base = results;
    issue_start();
    drive_beats(0, DEPTH, 20);
    wait_drain("busy_start_drain");
    repeat (5) tick();
    check("busy_start_results", 64'(results - res_base), 64'd1);
    check("busy_start_en", 64'(en_cycles - en_base), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
